// File: rtl/logic_gate_checker.sv
// logic_gate_checker: self-test engine for a two-input gate bank.
// It steps {a,b} through 00, 01, 10, 11 and holds each vector for
// SETTLE_CYCLES+1 cycles. On the last cycle of each vector it compares the
// seven gate outputs with their ideal values. It records the number of
// failing vectors, the first failing vector and that vector's mismatch mask.
module logic_gate_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_drv,
    output logic       b_drv,
    input  logic [6:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec,
    output logic [6:0] fail_mask
);

    // The settle counter is 4 bits wide, so S is bounded to 1..15.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("logic_gate_checker: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_reg;
    logic [1:0] vec_reg;
    logic [3:0] settle_reg;

    logic       vec_a;
    logic       vec_b;
    logic [6:0] expected;
    logic [6:0] mismatch;
    logic       vec_fails;
    logic       sample_last;

    // Expected outputs of an ideal gate bank for the current vector.
    always_comb begin
        vec_a    = vec_reg[1];
        vec_b    = vec_reg[0];
        expected = {~(vec_a ^ vec_b), vec_a ^ vec_b, ~(vec_a | vec_b),
                    ~(vec_a & vec_b), ~vec_a, vec_a | vec_b, vec_a & vec_b};
    end

    // Per-bit mismatch between the bank outputs and the ideal values.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_mismatch
            assign mismatch[gi] = gate_in[gi] ^ expected[gi];
        end
    endgenerate

    assign vec_fails   = |mismatch;
    assign sample_last = (settle_reg == SETTLE_LAST);

    // Run sequencer with registered outputs. A failure on the final sample
    // still affects pass. For that reason pass is computed from the
    // pre-update error count and this cycle's mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            vec_reg    <= 2'd0;
            settle_reg <= 4'd0;
            a_drv      <= 1'b0;
            b_drv      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 2'd0;
            fail_mask  <= 7'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    a_drv <= 1'b0;
                    b_drv <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        state_reg  <= S_DRIVE;
                        vec_reg    <= 2'd0;
                        settle_reg <= 4'd0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= 3'd0;
                        fail_vec   <= 2'd0;
                        fail_mask  <= 7'd0;
                    end
                end
                S_DRIVE: begin
                    if (sample_last) begin
                        if (vec_fails) begin
                            err_count <= err_count + 3'd1;
                            if (err_count == 3'd0) begin
                                fail_vec  <= vec_reg;
                                fail_mask <= mismatch;
                            end
                        end
                        if (vec_reg == 2'd3) begin
                            state_reg <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            a_drv     <= 1'b0;
                            b_drv     <= 1'b0;
                            pass      <= (err_count == 3'd0) && !vec_fails;
                        end else begin
                            vec_reg          <= vec_reg + 2'd1;
                            settle_reg       <= 4'd0;
                            {a_drv, b_drv}   <= vec_reg + 2'd1;
                        end
                    end else begin
                        settle_reg <= settle_reg + 4'd1;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/logic_gate_checker.md
# logic_gate_checker

Self-test engine for the two-input gate bank. On a start pulse it drives all four input combinations onto the gate bank's `a`/`b` inputs and waits a programmable settle time. It then samples the seven gate outputs and compares them against internally computed expected values. It sits on the driving side of the gate bank and reports pass/fail, the first failing vector, the failing-output mask and the error count.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range is 1..15; elaboration must fail outside that range.

Ports:
- `clk`  in  1  clock. The design uses this single clock only; all logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  run request. Sampled only in IDLE.
- `a_drv`  out  1  drives the gate bank input `a`. Equals the current vector bit 1.
- `b_drv`  out  1  drives the gate bank input `b`. Equals the current vector bit 0.
- `gate_in`  in  7  gate bank outputs, with this bit order:
  - [0] and, [1] or, [2] not(a), [3] nand, [4] nor, [5] xor, [6] xnor.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  high when the last run had zero mismatching vectors.
- `err_count`  out  3  number of failing vectors in the last run, 0..4.
- `fail_vec`  out  2  {a,b} of the first failing vector.
- `fail_mask`  out  7  `gate_in ^ expected` for the first failing vector.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE
  - `a_drv` = `b_drv` = 0, `busy` = 0.
  - `start` = 1 moves to DRIVE with vector index `vec` = 0, settle counter = 0.
  - Accepting `start` clears `pass`, `err_count`, `fail_vec` and `fail_mask`.
- DRIVE
  - `busy` = 1, `{a_drv,b_drv}` = `vec`, driven from registers.
  - The settle counter counts 0..`SETTLE_CYCLES`, so each vector occupies `SETTLE_CYCLES`+1 cycles.
  - On the cycle the counter equals `SETTLE_CYCLES` (the sample cycle), `gate_in` is compared with `expected(vec)`:
    - `expected` = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}, mapped to bits [6:0].
  - On a nonzero mismatch:
    - `err_count` increments.
    - If `err_count` was 0, `fail_vec` ← `vec` and `fail_mask` ← mismatch.
  - After the sample cycle:
    - If `vec` = 3, go to DONE.
    - Otherwise `vec` increments and the counter returns to 0.
- DONE
  - Lasts one cycle: `busy` = 0, `done` = 1.
  - `pass` ← (`err_count` == 0), including the update from the final sample.
  - Next state is IDLE.
- Results hold until the next accepted `start` or `rst`.
- `start` in DRIVE or DONE is ignored, not queued.
- `err_count` saturates naturally at 4; it cannot exceed 4.
- `gate_in` is sampled only in sample cycles. Its value at any other time has no effect.

## Timing
- Reset value of every output is 0: `a_drv`, `b_drv`, `busy`, `done`, `pass`, `err_count`, `fail_vec`, `fail_mask`.
- `rst` dominates `start`. `rst` during DRIVE aborts the run: state goes to IDLE on the next edge, no `done` is produced and all results are cleared.
- Run timeline, with `start` high in cycle T and S = `SETTLE_CYCLES`:
  - `busy` = 1 in cycles T+1 .. T+4(S+1).
  - `done` pulses in cycle T+4(S+1)+1.
  - With S = 2: `busy` in T+1..T+12, `done` in T+13.
- Vector k is driven in cycles T+1+k(S+1) .. T+(k+1)(S+1). It is sampled at the rising edge ending the last of those cycles.
- `start` asserted in the cycle after DONE (back in IDLE) is accepted, so back-to-back runs need no idle gap beyond the DONE cycle.
- `pass`, `err_count`, `fail_vec` and `fail_mask` are stable and valid from the `done` cycle onward.

## Test plan
- Correct gate bank model, S = 2, `start` at T: `a_drv`/`b_drv` step 00, 01, 10, 11 every 3 cycles. Required response: `done` at T+13, `pass` = 1, `err_count` = 0, `fail_mask` = 0.
- `gate_in[5]` (xor) stuck at 0: `err_count` = 2, `fail_vec` = 2'b01, `fail_mask` = 7'b0100000, `pass` = 0.
- `gate_in[2]` wired to `b` instead of `~a`: vectors 00 and 11 fail, so `err_count` = 2, `fail_vec` = 2'b00, `fail_mask` = 7'b0000100.
- `start` re-pulsed at T+5 during a run: ignored, a single `done` at T+13. `start` again at T+14: the second run's `done` arrives at T+27.
- `rst` pulsed at T+6: from T+7 `busy` = 0, `a_drv` = `b_drv` = 0 and all results are 0; no `done` appears through T+20.
- S = 1 with a correct model: `busy` in T+1..T+8, `done` at T+9, `pass` = 1.
